of_hazard_scoreboard: RTL
=========================

# of_hazard_scoreboard

Operand-fetch hazard controller that sequences instruction issue from the OF stage into EX. Keeps a per-GPR pending-write counter, stalls OF on read-after-write and counter-overflow hazards, and retires pending writes on writeback or squash. Provides a drain sequence that holds issue until every in-flight write has retired, for returns, PC-register accesses and pipeline start. Sits beside OF; its stall term feeds OF's `stall_of` and its issue strobe qualifies the OF→EX handshake.

## Interface

Parameters:
- `NUM_REGS`, 16: number of GPRs tracked; address width is log2(`NUM_REGS`).
- `CNT_W`, 2: width of each pending-write counter; maximum outstanding writes per register is 2^`CNT_W`−1.

Ports:
- `Clk` in 1: clock; all state updates on the rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `Start` in 1: level; enables leaving `WAIT_START`.
- `Of_Valid_i` in 1: OF holds a decoded instruction.
- `Rs1_Addr_i` in 4: first source register; same register as GPR read port 1.
- `Rs1_Used_i` in 1: instruction reads `Rs1_Addr_i`.
- `Rs2_Addr_i` in 4: second source register; same register as GPR read port 2, i.e. rd for stores.
- `Rs2_Used_i` in 1: instruction reads `Rs2_Addr_i`.
- `Rd_Addr_i` in 4: destination register.
- `Rd_Wr_i` in 1: instruction writes `Rd_Addr_i`.
- `Drain_Req_i` in 1: instruction in OF requires an empty scoreboard before issue (isRet, accesses to reg 15).
- `Ex_Ready_i` in 1: EX can accept.
- `Wb_Valid_i` in 1: a write to `Wb_Addr_i` retires this cycle.
- `Wb_Addr_i` in 4: writeback register.
- `Kill_Valid_i` in 1: an in-flight writer to `Kill_Addr_i` was squashed.
- `Kill_Addr_i` in 4: squashed writer's destination.
- `Stall_o` out 1: OF must not issue (combinational).
- `Issue_o` out 1: instruction transfers OF→EX this cycle (combinational).
- `Busy_Mask_o` out `NUM_REGS`: bit r = counter[r] ≠ 0 (from registered state).
- `Drain_Done_o` out 1: registered one-cycle pulse when a drain completes.
- `Err_o` out 1: sticky; set when a decrement targets a zero counter.

## Operation

- State machine:
  - `WAIT_START`: entered on reset. `Stall_o`=1. Moves to `RUN` on the first edge with `Start`=1.
  - `RUN`: normal operation. If `Of_Valid_i`·`Drain_Req_i` and any counter is nonzero, move to `DRAIN`.
  - `DRAIN`: `Stall_o`=1. When all counters are 0, pulse `Drain_Done_o` and return to `RUN`. The waiting instruction then issues through the normal rules, so issue is at least 1 cycle after the pulse.
- `Of_Valid_i`·`Drain_Req_i` with all counters already 0 in `RUN`: no drain. Issue proceeds normally and `Drain_Done_o` stays 0.
- Hazard in `RUN`, asserted when `Of_Valid_i` is high and any of the following holds:
  - `Rs1_Used_i` and counter[`Rs1_Addr_i`] ≠ 0;
  - `Rs2_Used_i` and counter[`Rs2_Addr_i`] ≠ 0;
  - `Rd_Wr_i` and counter[`Rd_Addr_i`] = 2^`CNT_W`−1 (overflow guard).
- `Stall_o` = (state ≠ `RUN`) | hazard | (`Of_Valid_i`·`Drain_Req_i`·any counter ≠ 0).
- `Issue_o` = `Of_Valid_i` · `Ex_Ready_i` · ¬`Stall_o`.
- Hazard checks use registered counters only. A writeback in the same cycle does not unblock; the stall releases the following cycle.
- Counter update, per register r:
  - next = cnt + inc − dec_wb − dec_kill, where each term is 0 or 1.
  - inc = `Issue_o`·`Rd_Wr_i`·(`Rd_Addr_i`=r).
  - Issue and retire of the same register in the same cycle give a net change of 0.
  - Wb and kill of the same register in the same cycle give a decrement of 2.
- Decrement below 0: clamp the counter at 0 and set `Err_o`. `Err_o` clears only on `Rst`.
- Counters never wrap; the overflow guard makes an increment at maximum impossible.
- Wb and kill inputs are honoured in every state, including `WAIT_START` and `DRAIN`.

## Timing

- Reset values: all counters 0, state `WAIT_START`.
  - `Stall_o`=1, `Issue_o`=0, `Busy_Mask_o`=0, `Drain_Done_o`=0, `Err_o`=0.
- Asynchronous reset mid-drain or mid-stall: immediate return to the reset state; all pending counts are discarded.
- Back-to-back dependent pair (writer issues at cycle t, wb at cycle t+k):
  - the reader stalls in cycles t+1…t+k;
  - the reader issues at t+k+1 at the earliest.
- Independent instructions issue every cycle while `Ex_Ready_i`=1.
- `Ex_Ready_i`=0 with no hazard: `Stall_o`=0 and `Issue_o`=0, and the OF payload is held by the OF pipe.
- `Busy_Mask_o` reflects counters after the previous edge; it does not include this cycle's updates.

## Test plan

- Reset then `Start`=0 for 5 cycles → `Stall_o`=1, `Issue_o`=0. `Start`=1 → `RUN` on the next edge, and `Stall_o`=0 with a valid, independent instruction.
- Issue writer rd=3 at t. Reader rs1=3 valid from t+1, wb rd=3 at t+4 → `Stall_o`=1 in t+1…t+4, reader `Issue_o`=1 at t+5, `Busy_Mask_o`[3]=1 during t+1…t+4.
- Issue writers rd=5 three times (`CNT_W`=2), then a fourth writer rd=5 → fourth stalls (overflow guard). One wb rd=5 → fourth issues next cycle, and counter[5] returns to 3.
- Issue rd=7 then rd=2. Then, in the same cycle, issue a new rd=7, wb rd=7 and kill rd=2 → counter[7] stays 1, counter[2]=0, `Err_o`=0.
- With counters 4 and 9 pending, assert a `Drain_Req_i` instruction → `DRAIN`, `Stall_o`=1. Retire both → `Drain_Done_o` single pulse, then issue in `RUN`.
- Wb to register 6 with counter[6]=0 → counter stays 0, `Err_o`=1 and stays 1 until `Rst`. Assert `Rst` mid-`DRAIN` → all outputs return to reset values immediately.

Source files
------------

// File: rtl/of_hazard_scoreboard.sv
// rtl/of_hazard_scoreboard.sv - operand-fetch RAW/overflow hazard scoreboard with drain sequencing
//
// Tracks a small pending-write counter per GPR. OF is stalled while any source
// register has an outstanding writer, while the destination counter is saturated,
// and while a drain (ret / PC-register access) waits for every write to retire.
//
// Ports:
//   Clk, Rst          clock, asynchronous active-high reset
//   Start             level enable to leave WAIT_START
//   Of_Valid_i        OF holds a decoded instruction
//   Rs1_*/Rs2_*       source register addresses and use flags
//   Rd_Addr_i/Rd_Wr_i destination register and write flag
//   Drain_Req_i       instruction needs an empty scoreboard before issue
//   Ex_Ready_i        EX can accept
//   Wb_Valid_i/Addr   pending write retires by writeback
//   Kill_Valid_i/Addr pending write retires by squash
//   Stall_o           OF must not issue (combinational)
//   Issue_o           OF->EX transfer this cycle (combinational)
//   Busy_Mask_o       per-register counter != 0, from registered state
//   Drain_Done_o      registered one-cycle pulse when a drain completes
//   Err_o             sticky; a retire hit a zero counter

module of_hazard_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start,
  input  logic                Of_Valid_i,
  input  logic [AW-1:0]       Rs1_Addr_i,
  input  logic                Rs1_Used_i,
  input  logic [AW-1:0]       Rs2_Addr_i,
  input  logic                Rs2_Used_i,
  input  logic [AW-1:0]       Rd_Addr_i,
  input  logic                Rd_Wr_i,
  input  logic                Drain_Req_i,
  input  logic                Ex_Ready_i,
  input  logic                Wb_Valid_i,
  input  logic [AW-1:0]       Wb_Addr_i,
  input  logic                Kill_Valid_i,
  input  logic [AW-1:0]       Kill_Addr_i,
  output logic                Stall_o,
  output logic                Issue_o,
  output logic [NUM_REGS-1:0] Busy_Mask_o,
  output logic                Drain_Done_o,
  output logic                Err_o
);

  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    RUN        = 2'd1,
    DRAIN      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt     [NUM_REGS];
  logic [CNT_W-1:0] cnt_nxt [NUM_REGS];

  logic [NUM_REGS-1:0] busy;
  logic                any_busy;
  logic                nxt_any_busy;
  logic                hazard;
  logic                drain_hold;
  logic                err_set;

  // Busy view is taken from registered counters only; same-cycle retires do not unblock.
  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy[r] = |cnt[r];
    end
  end

  assign any_busy    = |busy;
  assign Busy_Mask_o = busy;

  always_comb begin
    hazard = 1'b0;
    if (Of_Valid_i) begin
      if (Rs1_Used_i && busy[Rs1_Addr_i]) hazard = 1'b1;
      if (Rs2_Used_i && busy[Rs2_Addr_i]) hazard = 1'b1;
      // A counter at maximum cannot take another writer without wrapping.
      if (Rd_Wr_i && (cnt[Rd_Addr_i] == CNT_MAX)) hazard = 1'b1;
    end
  end

  assign drain_hold = Of_Valid_i && Drain_Req_i && any_busy;
  assign Stall_o    = (state != RUN) || hazard || drain_hold;
  assign Issue_o    = Of_Valid_i && Ex_Ready_i && !Stall_o;

  // Per-register next count: +1 on issue of a writer, -1 each for writeback and kill.
  // Wide temporaries keep the sum exact so an underflow can be detected and clamped.
  always_comb begin
    logic [CNT_W+1:0] up;
    logic [CNT_W+1:0] dn;
    err_set      = 1'b0;
    nxt_any_busy = 1'b0;
    up           = '0;
    dn           = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      up = (CNT_W+2)'(cnt[r])
         + (CNT_W+2)'(Issue_o && Rd_Wr_i && (Rd_Addr_i == AW'(r)));
      dn = (CNT_W+2)'(Wb_Valid_i && (Wb_Addr_i == AW'(r)))
         + (CNT_W+2)'(Kill_Valid_i && (Kill_Addr_i == AW'(r)));
      if (dn > up) begin
        cnt_nxt[r] = '0;
        err_set    = 1'b1;
      end else begin
        cnt_nxt[r] = CNT_W'(up - dn);
      end
      nxt_any_busy = nxt_any_busy | (|cnt_nxt[r]);
    end
  end

  // Drain_Done_o is raised for the cycle in which the FSM sits in DRAIN with an empty
  // scoreboard, so the waiting instruction issues at the earliest one cycle later.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= WAIT_START;
      Drain_Done_o <= 1'b0;
      Err_o        <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      if (err_set) Err_o <= 1'b1;
      Drain_Done_o <= 1'b0;
      case (state)
        WAIT_START: begin
          if (Start) state <= RUN;
        end
        RUN: begin
          if (drain_hold) begin
            state        <= DRAIN;
            Drain_Done_o <= !nxt_any_busy;
          end
        end
        DRAIN: begin
          if (!any_busy) begin
            state <= RUN;
          end else begin
            Drain_Done_o <= !nxt_any_busy;
          end
        end
        default: state <= WAIT_START;
      endcase
    end
  end

endmodule
